data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Data-side memory controller between the CPU's MEM-stage data port (ce/we/addr/sel/wdata/rdata) and a synchronous single-port SRAM with fixed multi-cycle read latency.
- Replaces the zero-wait data RAM path. Adds a 1-entry posted write buffer and a read FSM, and raises stall_req to freeze the pipeline while a read is outstanding.

Parameters:
- RD_LAT, 2, SRAM read latency in cycles (legal 1..7); read data valid RD_LAT cycles after the issue cycle.
- MEM_AW, 16, SRAM word-address width; implemented range is byte addresses 0 .. 2^(MEM_AW+2)-1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_ce  in  1  data access request
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  byte address; bits [1:0] ignored (word access, lanes via sel)
- cpu_sel  in  4  byte-lane enables, bit i = byte i
- cpu_wdata  in  32  store data, lane-aligned
- cpu_rdata  out  32  load data, full word (CPU does lane extraction/extension)
- stall_req  out  1  combinational; 1 freezes the pipeline
- addr_err  out  1  combinational; access outside implemented range
- sram_ce  out  1  SRAM port enable
- sram_we  out  1  SRAM write strobe
- sram_addr  out  MEM_AW  SRAM word address (cpu_addr[MEM_AW+1:2])
- sram_be  out  4  SRAM byte enables
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data

Behaviour:
- Reset (rst=0, async): state=IDLE, wb_valid=0, wait counter=0, cpu_rdata=0; stall_req=0, sram_ce/we=0, sram_be=0, sram_addr/wdata=0. A pending buffered write or in-flight read is discarded.
- The CPU holds the request stable while stall_req=1. A request is consumed on the edge where stall_req=0.
- Range check: addr_err = cpu_ce & (cpu_addr[31:MEM_AW+2] != 0).
  - Errored access is a no-op: no SRAM cycle, no buffer capture, stall_req=0.
  - An errored load leaves cpu_rdata unchanged.
- Store with cpu_sel=0 is a no-op (no capture, no stall).
- Write buffer: one entry {word addr, be, data, wb_valid}.
  - State IDLE, wb_valid=1: SRAM port drives the buffered write this cycle (sram_ce=1, sram_we=1). Entry retires at the edge.
  - State IDLE, valid store: entry captured at the edge; stall_req=0. Capture and drain in the same cycle are legal; the new entry overwrites the draining one, so wb_valid stays 1.
  - Stores never stall.
- Read FSM states: IDLE, RD_WAIT, RD_DONE.
  - IDLE, valid load, wb_valid=1: stall_req=1; the drain occupies the port; stay IDLE. This guarantees read-after-write coherence with no forwarding.
  - IDLE, valid load, wb_valid=0: issue the read (sram_ce=1, sram_we=0, sram_be=cpu_sel); stall_req=1; counter<=RD_LAT-1; go to RD_WAIT.
  - RD_WAIT: stall_req=1; SRAM port idle.
    - Counter>0: decrement.
    - Counter==0: this cycle is issue+RD_LAT, so sram_rdata is valid. Capture it into cpu_rdata at the edge and go to RD_DONE.
  - RD_DONE: stall_req=0; cpu_rdata holds the loaded word; pipeline consumes it at the edge. Go to IDLE unconditionally. The still-present load is not re-issued.
- Load stall cycles: RD_LAT+1 with the buffer empty, RD_LAT+2 with the buffer full.
- Idle SRAM port: sram_ce=0, sram_we=0, sram_be=0. sram_addr/wdata may hold the last value.
- cpu_rdata changes only on a read capture or on reset.

Decomposition:
- Shared defines header (existing bus-width include): DataBus, DataAddrBus, FSM state encodings (IDLE=2'd0, RD_WAIT=2'd1, RD_DONE=2'd2), RdLatMax.
- Sub-module dmem_wbuf: the 1-entry posted write buffer, with capture/drain/valid logic and outputs to the SRAM mux.
- FSM, range check and port mux stay in data_mem_ctrl.

Test Plan:
- Reset mid-read: assert rst=0 during RD_WAIT -> state IDLE, stall_req=0, cpu_rdata=0 immediately (async); no SRAM strobe after release.
- Store then load, same word: store addr 0x10, sel 4'b1111, data 0xDEADBEEF; load 0x10 next cycle (RD_LAT=2).
  - Store: no stall.
  - Load: stall_req=1 for 4 cycles.
  - cpu_rdata=0xDEADBEEF in RD_DONE.
- Byte-lane store: word 0x20 = 0x11223344; store sel 4'b0100, data 0x00AA0000; load 0x20 -> 0x11AA3344.
- Back-to-back stores: stores to 0x0, 0x4, 0x8 on consecutive cycles -> stall_req never 1; three SRAM writes on consecutive cycles with the correct be/data.
- Latency sweep: RD_LAT=1 and RD_LAT=7, buffer empty -> stall_req high for exactly 2 and 8 cycles; exactly one sram_ce read pulse per load.
- Out of range: MEM_AW=16, load 0x00040000 -> addr_err=1, stall_req=0, no sram_ce, cpu_rdata unchanged; store there leaves memory untouched.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared widths, read-FSM state encoding and latency bound for the data-side
// memory controller.
package data_mem_ctrl_pkg;

  localparam int DataBus     = 32;
  localparam int DataAddrBus = 32;
  localparam int RdLatMax    = 7;
  localparam int CntW        = $clog2(RdLatMax + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// CPU MEM-stage data port: request/store-data from the CPU, load data and
// stall/error flags back from the controller.
interface data_mem_ctrl_if
  import data_mem_ctrl_pkg::*;
  ();

  logic                   cpu_ce;
  logic                   cpu_we;
  logic [DataAddrBus-1:0] cpu_addr;
  logic [3:0]             cpu_sel;
  logic [DataBus-1:0]     cpu_wdata;
  logic [DataBus-1:0]     cpu_rdata;
  logic                   stall_req;
  logic                   addr_err;

  modport master (
    output cpu_ce, cpu_we, cpu_addr, cpu_sel, cpu_wdata,
    input  cpu_rdata, stall_req, addr_err
  );

  modport slave (
    input  cpu_ce, cpu_we, cpu_addr, cpu_sel, cpu_wdata,
    output cpu_rdata, stall_req, addr_err
  );

endinterface

// File: rtl/data_mem_ctrl_wbuf.sv
// One-entry posted write buffer; a capture in the same cycle as a drain
// replaces the retiring entry.
module dmem_wbuf
  import data_mem_ctrl_pkg::*;
#(
  parameter int MEM_AW = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic               drain,
  input  logic [MEM_AW-1:0]  new_addr,
  input  logic [3:0]         new_be,
  input  logic [DataBus-1:0] new_data,
  output logic               wb_valid,
  output logic [MEM_AW-1:0]  wb_addr,
  output logic [3:0]         wb_be,
  output logic [DataBus-1:0] wb_data
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_be    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= capture | (wb_valid & ~drain);
      if (capture) begin
        wb_addr <= new_addr;
        wb_be   <= new_be;
        wb_data <= new_data;
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: range check, posted-write drain, and a read FSM that
// stalls the pipeline for the fixed SRAM read latency.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int MEM_AW = 16
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_ctrl_if.slave     cpu,
  output logic               sram_ce,
  output logic               sram_we,
  output logic [MEM_AW-1:0]  sram_addr,
  output logic [3:0]         sram_be,
  output logic [DataBus-1:0] sram_wdata,
  input  logic [DataBus-1:0] sram_rdata
);

  state_t              state, state_nxt;
  logic [CntW-1:0]     cnt, cnt_nxt;
  logic [DataBus-1:0]  rdata_q;
  logic                err, ld_req, st_req, capture, drain, rd_capture;
  logic                stall, port_ce, port_we;
  logic [MEM_AW-1:0]   port_addr, word_addr;
  logic [3:0]          port_be;
  logic [DataBus-1:0]  port_wdata;
  logic                wb_valid;
  logic [MEM_AW-1:0]   wb_addr;
  logic [3:0]          wb_be;
  logic [DataBus-1:0]  wb_data;

  assign err       = cpu.cpu_ce & ((cpu.cpu_addr >> (MEM_AW + 2)) != '0);
  assign word_addr = cpu.cpu_addr[MEM_AW+1:2];
  assign ld_req    = cpu.cpu_ce & ~cpu.cpu_we & ~err;
  assign st_req    = cpu.cpu_ce & cpu.cpu_we & ~err & (cpu.cpu_sel != '0);
  assign capture   = (state == IDLE) & st_req;
  assign drain     = (state == IDLE) & wb_valid;

  dmem_wbuf #(.MEM_AW(MEM_AW)) u_wbuf (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .drain    (drain),
    .new_addr (word_addr),
    .new_be   (cpu.cpu_sel),
    .new_data (cpu.cpu_wdata),
    .wb_valid (wb_valid),
    .wb_addr  (wb_addr),
    .wb_be    (wb_be),
    .wb_data  (wb_data)
  );

  // A pending drain owns the port, so a load waits in IDLE until the buffer
  // is empty; this keeps read-after-write coherent without forwarding.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    stall      = 1'b0;
    rd_capture = 1'b0;
    port_ce    = 1'b0;
    port_we    = 1'b0;
    port_addr  = '0;
    port_be    = '0;
    port_wdata = '0;
    case (state)
      IDLE: begin
        if (wb_valid) begin
          port_ce    = 1'b1;
          port_we    = 1'b1;
          port_addr  = wb_addr;
          port_be    = wb_be;
          port_wdata = wb_data;
          stall      = ld_req;
        end else if (ld_req) begin
          port_ce   = 1'b1;
          port_addr = word_addr;
          port_be   = cpu.cpu_sel;
          stall     = 1'b1;
          cnt_nxt   = CntW'(RD_LAT - 1);
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        stall = 1'b1;
        if (cnt == '0) begin
          rd_capture = 1'b1;
          state_nxt  = RD_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RD_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (rd_capture) rdata_q <= sram_rdata;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign cpu.stall_req = rst & stall;
  assign cpu.addr_err  = err;
  assign cpu.cpu_rdata = rdata_q;
  assign sram_ce       = rst & port_ce;
  assign sram_we       = rst & port_we;
  assign sram_addr     = rst ? port_addr : '0;
  assign sram_be       = rst ? port_be : '0;
  assign sram_wdata    = rst ? port_wdata : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: three controllers (RD_LAT 2, 1, 7) each with an SRAM model.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        ce [3];
  logic        we [3];
  logic [31:0] addr [3];
  logic [3:0]  sel [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        stall [3];
  logic        err [3];
  logic        s_ce [3];
  logic        s_we [3];
  logic [15:0] s_addr [3];
  logic [3:0]  s_be [3];
  logic [31:0] s_wdata [3];

  typedef struct { int k; logic [31:0] data; int stalls; } rd_exp_t;
  typedef struct { int k; logic [15:0] a; logic [3:0] be; logic [31:0] d; } wr_exp_t;

  rd_exp_t     rq[$];
  wr_exp_t     wq[$];
  int unsigned wr_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          st_cnt [3];
  int          rd_pulses [3];

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 7);
    data_mem_ctrl_if bus ();
    logic [31:0] mem [64];
    logic [31:0] pd [7];
    logic        pv [7];
    logic [31:0] srd;

    assign bus.cpu_ce    = ce[k];
    assign bus.cpu_we    = we[k];
    assign bus.cpu_addr  = addr[k];
    assign bus.cpu_sel   = sel[k];
    assign bus.cpu_wdata = wdata[k];
    assign rdata[k]      = bus.cpu_rdata;
    assign stall[k]      = bus.stall_req;
    assign err[k]        = bus.addr_err;

    data_mem_ctrl #(.RD_LAT(LAT), .MEM_AW(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu        (bus),
      .sram_ce    (s_ce[k]),
      .sram_we    (s_we[k]),
      .sram_addr  (s_addr[k]),
      .sram_be    (s_be[k]),
      .sram_wdata (s_wdata[k]),
      .sram_rdata (srd)
    );

    assign srd = pv[LAT-1] ? pd[LAT-1] : 32'hBAD0_BAD0;

    always @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        for (int i = 0; i < 7; i++) begin
          pv[i] <= 1'b0;
          pd[i] <= '0;
        end
      end else begin
        pv[0] <= s_ce[k] & ~s_we[k];
        pd[0] <= mem[s_addr[k][5:0]];
        for (int i = 1; i < 7; i++) begin
          pv[i] <= pv[i-1];
          pd[i] <= pd[i-1];
        end
        if (s_ce[k] && s_we[k])
          for (int b = 0; b < 4; b++)
            if (s_be[k][b]) mem[s_addr[k][5:0]][8*b +: 8] <= s_wdata[k][8*b +: 8];
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin : monitor
    rd_exp_t rx;
    wr_exp_t wx;
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        if (s_ce[k] && !s_we[k]) rd_pulses[k]++;
        if (s_ce[k] && s_we[k]) begin
          wr_cyc.push_back(cyc);
          if (wq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write inst %0d: got addr %h be %h data %h, required none",
                     k, s_addr[k], s_be[k], s_wdata[k]);
          end else begin
            wx = wq.pop_front();
            chk("wr_inst", 32'(k), 32'(wx.k));
            chk("wr_addr", 32'(s_addr[k]), 32'(wx.a));
            chk("wr_be", 32'(s_be[k]), 32'(wx.be));
            chk("wr_data", s_wdata[k], wx.d);
          end
        end
        if (ce[k] && !we[k] && !err[k]) begin
          if (stall[k]) st_cnt[k]++;
          else if (rq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_load_done inst %0d: got rdata %h, required none", k, rdata[k]);
          end else begin
            rx = rq.pop_front();
            chk("ld_inst", 32'(k), 32'(rx.k));
            chk("ld_rdata", rdata[k], rx.data);
            chk("ld_stall_cycles", 32'(st_cnt[k]), 32'(rx.stalls));
            chk("ld_read_pulses", 32'(rd_pulses[k]), 32'd1);
            st_cnt[k]    = 0;
            rd_pulses[k] = 0;
          end
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        st_cnt[k]    = 0;
        rd_pulses[k] = 0;
      end
    end
  end

  task automatic idle(int k, int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ce[k] = 1'b0;
      we[k] = 1'b0;
    end
  endtask

  task automatic store(int k, logic [31:0] a, logic [3:0] s, logic [31:0] d, bit exp_wr, bit exp_err);
    @(posedge clk);
    #1;
    ce[k] = 1'b1; we[k] = 1'b1; addr[k] = a; sel[k] = s; wdata[k] = d;
    if (exp_wr) wq.push_back('{k, a[17:2], s, d});
    @(negedge clk);
    chk("store_stall", 32'(stall[k]), 32'd0);
    chk("store_addr_err", 32'(err[k]), 32'(exp_err));
  endtask

  task automatic load(int k, logic [31:0] a, logic [3:0] s, logic [31:0] exp_d, int exp_st, bit exp_err);
    int n;
    @(posedge clk);
    #1;
    ce[k] = 1'b1; we[k] = 1'b0; addr[k] = a; sel[k] = s;
    if (exp_err) begin
      @(negedge clk);
      chk("err_ld_addr_err", 32'(err[k]), 32'd1);
      chk("err_ld_stall", 32'(stall[k]), 32'd0);
      chk("err_ld_sram_ce", 32'(s_ce[k]), 32'd0);
      chk("err_ld_rdata_held", rdata[k], exp_d);
    end else begin
      rq.push_back('{k, exp_d, exp_st});
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (stall[k] && n < 40);
      if (stall[k]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL load_timeout inst %0d: stall_req still 1 after %0d cycles, required 0", k, n);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      ce[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; sel[k] = '0; wdata[k] = '0;
    end
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", 32'(stall[k]), 32'd0);
      chk("rst_sram_ce", 32'(s_ce[k]), 32'd0);
      chk("rst_sram_we", 32'(s_we[k]), 32'd0);
      chk("rst_sram_be", 32'(s_be[k]), 32'd0);
      chk("rst_sram_addr", 32'(s_addr[k]), 32'd0);
      chk("rst_sram_wdata", s_wdata[k], 32'd0);
      chk("rst_rdata", rdata[k], 32'd0);
    end
    #10 rst = 1'b1;

    // Reset asserted while a read is waiting on the SRAM.
    @(posedge clk);
    #1;
    ce[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h40; sel[0] = 4'hF;
    @(negedge clk);
    @(negedge clk);
    chk("midread_stall", 32'(stall[0]), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midread_rst_stall", 32'(stall[0]), 32'd0);
    chk("midread_rst_rdata", rdata[0], 32'd0);
    chk("midread_rst_sram_ce", 32'(s_ce[0]), 32'd0);
    ce[0] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_reads", 32'(rd_pulses[0]), 32'd0);
    chk("post_rst_stall", 32'(stall[0]), 32'd0);

    store(0, 32'h10, 4'hF, 32'hDEAD_BEEF, 1, 0);
    load(0, 32'h10, 4'hF, 32'hDEAD_BEEF, 4, 0);

    store(0, 32'h20, 4'hF, 32'h1122_3344, 1, 0);
    store(0, 32'h20, 4'b0100, 32'h00AA_0000, 1, 0);
    load(0, 32'h20, 4'hF, 32'h11AA_3344, 4, 0);

    wr_cyc.delete();
    store(0, 32'h0, 4'hF, 32'h0102_0304, 1, 0);
    store(0, 32'h4, 4'b0011, 32'h0000_BEEF, 1, 0);
    store(0, 32'h8, 4'b1000, 32'hCC00_0000, 1, 0);
    load(0, 32'h8, 4'hF, 32'hCC00_0002, 4, 0);
    chk("b2b_write_count", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) begin
      chk("b2b_write_gap1", wr_cyc[1] - wr_cyc[0], 32'd1);
      chk("b2b_write_gap2", wr_cyc[2] - wr_cyc[1], 32'd1);
    end
    load(0, 32'h4, 4'hF, 32'hA500_BEEF, 3, 0);

    store(0, 32'hC, 4'h0, 32'hFFFF_FFFF, 0, 0);
    load(0, 32'hC, 4'hF, 32'hA500_0003, 3, 0);

    load(0, 32'h0004_0000, 4'hF, 32'hA500_0003, 0, 1);
    store(0, 32'h0004_0000, 4'hF, 32'hFFFF_FFFF, 0, 1);
    load(0, 32'h0, 4'hF, 32'h0102_0304, 3, 0);
    idle(0, 2);

    load(1, 32'h14, 4'hF, 32'hA500_0005, 2, 0);
    idle(1, 2);
    load(2, 32'h18, 4'hF, 32'hA500_0006, 8, 0);
    store(2, 32'h18, 4'b0001, 32'h0000_0077, 1, 0);
    load(2, 32'h18, 4'hF, 32'hA500_0077, 9, 0);
    idle(2, 3);

    chk("leftover_loads", 32'(rq.size()), 32'd0);
    chk("leftover_writes", 32'(wq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
